bus_slave_mem: RTL and testbench

- Memory-mapped word-RAM slave on the shared system bus; it is the responder end of the `as_`/`rw`/`rdy_` access handshake driven by the CPU bus interface.
- Sits behind the bus address decoder, which supplies `cs_`.
- Accepts one access per `as_` pulse and inserts a programmable number of wait states.
- Returns `rdy_` with read data, or write completion, as a registered single-cycle response.

---
 rtl/bus_slave_mem.sv | 106 ++++++++++
 tb/tb_bus_slave_mem.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_mem.sv
// Word-RAM responder on the system bus as_/rw/rdy_ handshake.
// One access per as_ strobe, WAIT_CYCLES wait states, registered one-cycle rdy_ response.
module bus_slave_mem #(
  parameter  int DEPTH_LOG2  = 10,
  parameter  int WAIT_CYCLES = 2,
  localparam int WORD_ADDR_W = 30,
  localparam int WORD_DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cs_,
  input  logic                   as_,
  input  logic                   rw,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic [WORD_DATA_W-1:0] wr_data,
  output logic [WORD_DATA_W-1:0] rd_data,
  output logic                   rdy_
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic                    rw_q, rw_d;
  logic [WORD_DATA_W-1:0]  wdata_q, wdata_d;
  logic [WORD_DATA_W-1:0]  rd_data_q, rd_data_d;
  logic                    rdy_q, rdy_d;
  logic                    mem_we;

  logic [WORD_DATA_W-1:0]  mem [DEPTH];

  // Address bits above the decoded window alias onto the same words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[WORD_ADDR_W-1:DEPTH_LOG2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    rd_data_d = '0;
    rdy_d     = 1'b1;
    mem_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cs_ && !as_) begin
          addr_d  = addr[DEPTH_LOG2-1:0];
          rw_d    = rw;
          wdata_d = wr_data;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Counter reaching zero marks the edge WAIT_CYCLES+1 after acceptance.
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          rdy_d   = 1'b0;
          if (rw_q) rd_data_d = mem[addr_q];
          else      mem_we    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      rdy_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      rdy_q     <= rdy_d;
    end
  end

  // Storage is not reset; a reset edge suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[addr_q] <= wdata_q;
  end

  assign rd_data = rd_data_q;
  assign rdy_    = rdy_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Bench for bus_slave_mem: default build (2 wait states) plus a zero-wait build,
// checked against an array model of the word store and the handshake timing rules.
module tb_bus_slave_mem;
  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cs_n, as_n, rw;
  logic [29:0] addr;
  logic [31:0] wr_data, rd_data;
  logic        rdy_n;

  logic        cs0_n, as0_n, rw0;
  logic [29:0] addr0;
  logic [31:0] wr0, rd0;
  logic        rdy0_n;

  bus_slave_mem #(.DEPTH_LOG2(10), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .cs_(cs_n), .as_(as_n), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_n));

  bus_slave_mem #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .cs_(cs0_n), .as_(as0_n), .rw(rw0), .addr(addr0),
    .wr_data(wr0), .rd_data(rd0), .rdy_(rdy0_n));

  int total = 0;
  int bad   = 0;

  logic [31:0] model [1024];
  logic [31:0] model0 [1024];

  // One access on the default DUT. The response must appear only in the
  // cycle after edge W+1 (edge 0 = accepting edge). Optionally strobes a
  // competing write to 0x006 during WAIT and during RESP, which must be ignored.
  task automatic access(input logic rw_i, input logic [29:0] a, input logic [31:0] d,
                        input bit intrude, input string name);
    logic [31:0] exp_rd;
    int lows;
    lows = 0;
    exp_rd = model[a[9:0]];
    @(negedge clk);
    cs_n = 1'b0; as_n = 1'b0; rw = rw_i; addr = a; wr_data = d;
    @(negedge clk);
    if (!rw_i) model[a[9:0]] = d;
    for (int k = 0; k <= W + 2; k++) begin
      if (k == W + 1) begin
        total++;
        if (rdy_n !== 1'b0) begin
          bad++; $display("FAIL %s rdy k=%0d got=%b want=0", name, k, rdy_n);
        end
        total++;
        if (rd_data !== (rw_i ? exp_rd : 32'h0)) begin
          bad++; $display("FAIL %s rd_data got=%h want=%h", name, rd_data, rw_i ? exp_rd : 32'h0);
        end
      end else begin
        total++;
        if (rdy_n !== 1'b1 || rd_data !== 32'h0) begin
          bad++; $display("FAIL %s idle k=%0d rdy=%b rd=%h want rdy=1 rd=0", name, k, rdy_n, rd_data);
        end
      end
      if (rdy_n === 1'b0) lows++;
      if (intrude && (k == 1 || k == W + 1)) begin
        cs_n = 1'b0; as_n = 1'b0; rw = 1'b0; addr = 30'h006; wr_data = $urandom;
      end else begin
        cs_n = 1'b1; as_n = 1'b1; rw = 1'($urandom); addr = 30'($urandom); wr_data = $urandom;
      end
      @(negedge clk);
    end
    total++;
    if (lows != 1) begin
      bad++; $display("FAIL %s rdy_pulses got=%0d want=1", name, lows);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; as_n = 1'b1; rw = 1'b1; addr = '0; wr_data = '0;
    cs0_n = 1'b1; as0_n = 1'b1; rw0 = 1'b1; addr0 = '0; wr0 = '0;
    repeat (3) @(negedge clk);
    total++;
    if (rdy_n !== 1'b1 || rd_data !== 32'h0) begin
      bad++; $display("FAIL reset rdy=%b rd=%h want rdy=1 rd=0", rdy_n, rd_data);
    end
    total++;
    if (rdy0_n !== 1'b1 || rd0 !== 32'h0) begin
      bad++; $display("FAIL reset0 rdy=%b rd=%h want rdy=1 rd=0", rdy0_n, rd0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    access(1'b0, 30'h005, 32'hDEADBEEF, 0, "wr5");
    access(1'b1, 30'h005, 32'h0, 0, "rd5");
  endtask

  task automatic test_ignored();
    int lows;
    access(1'b0, 30'h006, 32'h66666666, 0, "pre6");
    lows = 0;
    @(negedge clk);
    cs_n = 1'b1; as_n = 1'b0; rw = 1'b0; addr = 30'h006; wr_data = 32'hBADBAD00;
    @(negedge clk);
    as_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      if (rdy_n === 1'b0) lows++;
      @(negedge clk);
    end
    total++;
    if (lows != 0) begin
      bad++; $display("FAIL cs_high rdy_pulses got=%0d want=0", lows);
    end
    access(1'b0, 30'h007, 32'h77777777, 1, "wr7_intrude");
    access(1'b1, 30'h006, 32'h0, 0, "rd6_unchanged");
  endtask

  task automatic test_alias();
    access(1'b0, 30'h405, 32'h12345678, 0, "wr405");
    access(1'b1, 30'h005, 32'h0, 0, "rd5_alias");
    access(1'b1, 30'h3FFF_FC05, 32'h0, 0, "rd_hi_alias");
  endtask

  task automatic test_reset_mid();
    int lows;
    access(1'b0, 30'h010, 32'h01010101, 0, "pre10");
    lows = 0;
    @(negedge clk);
    cs_n = 1'b0; as_n = 1'b0; rw = 1'b0; addr = 30'h010; wr_data = 32'hCAFEF00D;
    @(negedge clk);
    cs_n = 1'b1; as_n = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      if (rdy_n === 1'b0) lows++;
      if (k == 1) rst = 1'b0;
      @(negedge clk);
    end
    total++;
    if (lows != 0) begin
      bad++; $display("FAIL abort rdy_pulses got=%0d want=0", lows);
    end
    access(1'b1, 30'h010, 32'h0, 0, "rd10_after_abort");
  endtask

  task automatic test_random();
    logic [9:0] idx [8];
    for (int i = 0; i < 8; i++) begin
      idx[i] = 10'(32 + i * 97);
      access(1'b0, {20'($urandom), idx[i]}, $urandom, 0, "rnd_init");
    end
    for (int n = 0; n < 40; n++) begin
      access(1'($urandom), {20'($urandom), idx[$urandom_range(0, 7)]}, $urandom, 0, "rnd");
    end
  endtask

  // Zero-wait build: each rdy_ one cycle after acceptance; second strobe is
  // presented in the first IDLE cycle after the first response and must be taken.
  task automatic test_back_to_back();
    logic [31:0] v3, v4;
    logic exp_rdy;
    logic [31:0] exp_rd;
    v3 = $urandom; v4 = $urandom;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      cs0_n = 1'b0; as0_n = 1'b0; rw0 = 1'b0; addr0 = 30'(3 + j); wr0 = j ? v4 : v3;
      @(negedge clk);
      cs0_n = 1'b1; as0_n = 1'b1;
      model0[3 + j] = j ? v4 : v3;
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    cs0_n = 1'b0; as0_n = 1'b0; rw0 = 1'b1; addr0 = 30'h003;
    // k counts edges after the first accepting edge (0); second accept at 3.
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      exp_rdy = !(k == 1 || k == 4);
      exp_rd  = (k == 1) ? model0[3] : (k == 4) ? model0[4] : 32'h0;
      total++;
      if (rdy0_n !== exp_rdy || rd0 !== exp_rd) begin
        bad++; $display("FAIL b2b k=%0d rdy=%b rd=%h want rdy=%b rd=%h", k, rdy0_n, rd0, exp_rdy, exp_rd);
      end
      if (k == 1) begin
        cs0_n = 1'b1; as0_n = 1'b1;
      end else if (k == 2) begin
        cs0_n = 1'b0; as0_n = 1'b0; rw0 = 1'b1; addr0 = 30'h004;
      end else begin
        cs0_n = 1'b1; as0_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_ignored();
    test_alias();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
